// File: rtl/reg_xfer_pkg.sv
// Shared encodings for the register-transfer sequencer: opcodes, register map
// indices and FSM state codes.
package reg_xfer_pkg;

   localparam logic [1:0] OP_MOV  = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_SWAP = 2'b11;

   localparam int REG_ACC  = 0;
   localparam int REG_X    = 1;
   localparam int REG_Y    = 2;
   localparam int REG_FR   = 3;
   localparam int REG_SP   = 4;
   localparam int REG_PC   = 5;
   localparam int REG_LAST = 5;

   localparam int FR_W = 4;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ERR  = 3'd1;
   localparam logic [2:0] ST_RD1  = 3'd2;
   localparam logic [2:0] ST_RD2  = 3'd3;
   localparam logic [2:0] ST_WR1  = 3'd4;
   localparam logic [2:0] ST_WR2  = 3'd5;
   localparam logic [2:0] ST_FLG  = 3'd6;

endpackage

// File: rtl/reg_xfer_incdec.sv
// Combinational increment/decrement unit: result plus carry/borrow, negative
// and zero flags for the value read from the source register.
module reg_xfer_incdec
   import reg_xfer_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [1:0]    op,
   input  logic [DW-1:0] a,
   output logic [DW-1:0] result,
   output logic          c,
   output logic          n,
   output logic          z
);

   logic [DW:0] ext;

   // One extra bit on top captures the INC carry or the DEC borrow.
   always_comb begin
      ext = {1'b0, a};
      case (op)
         OP_INC:  ext = {1'b0, a} + (DW+1)'(1);
         OP_DEC:  ext = {1'b0, a} - (DW+1)'(1);
         default: ext = {1'b0, a};
      endcase
   end

   assign result = ext[DW-1:0];
   assign c      = ((op == OP_INC) || (op == OP_DEC)) && ext[DW];
   assign n      = result[DW-1];
   assign z      = (result == '0);

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer (MOV/INC/DEC/SWAP) driving the register file ports.
// Optional macro REGXFER_FLAGS_EN adds an FR flag-update state after INC/DEC.
module reg_xfer_ctrl
   import reg_xfer_pkg::*;
#(
   parameter int DW   = 16,
   parameter int SELW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [SELW-1:0] cmd_src,
   input  logic [SELW-1:0] cmd_dst,
   output logic [SELW-1:0] rf_s_out,
   output logic            rf_out_en,
   input  logic [DW-1:0]   rf_d_out,
   output logic [SELW-1:0] rf_s_in,
   output logic [DW-1:0]   rf_d_in,
   output logic            rf_write_en,
   output logic            done,
   output logic            err
);

   localparam logic [SELW-1:0] LAST_SEL = SELW'(REG_LAST);
   localparam logic [SELW-1:0] FR_SEL   = SELW'(REG_FR);

   logic [2:0]      state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [SELW-1:0] src_q, src_d;
   logic [SELW-1:0] dst_q, dst_d;
   logic [DW-1:0]   tmp_a_q, tmp_a_d;
   logic [DW-1:0]   tmp_b_q, tmp_b_d;

   logic [DW-1:0]   result;
   logic            flag_c, flag_n, flag_z;
   logic            flg_needed;

   // FR is only FR_W bits wide; anything written there is trimmed here.
   function automatic logic [DW-1:0] fr_trim(input logic [DW-1:0] v,
                                             input logic [SELW-1:0] sel);
      fr_trim = (sel == FR_SEL) ? {{(DW-FR_W){1'b0}}, v[FR_W-1:0]} : v;
   endfunction

   reg_xfer_incdec #(.DW(DW)) u_incdec (
      .op     (op_q),
      .a      (tmp_a_q),
      .result (result),
      .c      (flag_c),
      .n      (flag_n),
      .z      (flag_z)
   );

`ifdef REGXFER_FLAGS_EN
   assign flg_needed = ((op_q == OP_INC) || (op_q == OP_DEC)) && (dst_q != FR_SEL);
`else
   logic unused_flags;
   assign flg_needed   = 1'b0;
   assign unused_flags = ^{flag_c, flag_n, flag_z};
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      src_d   = src_q;
      dst_d   = dst_q;
      tmp_a_d = tmp_a_q;
      tmp_b_d = tmp_b_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               src_d   = cmd_src;
               dst_d   = cmd_dst;
               state_d = ((cmd_src > LAST_SEL) || (cmd_dst > LAST_SEL)) ? ST_ERR : ST_RD1;
            end
         end
         ST_RD1: begin
            tmp_a_d = rf_d_out;
            state_d = (op_q == OP_SWAP) ? ST_RD2 : ST_WR1;
         end
         ST_RD2: begin
            tmp_b_d = rf_d_out;
            state_d = ST_WR1;
         end
         ST_WR1: begin
            if (op_q == OP_SWAP)
               state_d = ST_WR2;
            else if (flg_needed)
               state_d = ST_FLG;
            else
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore outputs: everything below depends on registered state only.
   always_comb begin
      cmd_ready   = (state_q == ST_IDLE);
      rf_out_en   = (state_q == ST_RD1) || (state_q == ST_RD2);
      rf_write_en = (state_q == ST_WR1) || (state_q == ST_WR2) || (state_q == ST_FLG);
      err         = (state_q == ST_ERR);
      done        = 1'b0;
      rf_s_out    = '0;
      rf_s_in     = '0;
      rf_d_in     = '0;
      case (state_q)
         ST_RD1: rf_s_out = src_q;
         ST_RD2: rf_s_out = dst_q;
         ST_WR1: begin
            rf_s_in = dst_q;
            rf_d_in = fr_trim(result, dst_q);
            done    = (op_q != OP_SWAP) && !flg_needed;
         end
         ST_WR2: begin
            rf_s_in = src_q;
            rf_d_in = fr_trim(tmp_b_q, src_q);
            done    = 1'b1;
         end
         ST_FLG: begin
            rf_s_in = FR_SEL;
            rf_d_in = {{(DW-3){1'b0}}, flag_c, flag_n, flag_z};
            done    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         tmp_a_q <= '0;
         tmp_b_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         tmp_a_q <= tmp_a_d;
         tmp_b_q <= tmp_b_d;
      end
   end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl with a behavioural register file model.
module tb_reg_xfer_ctrl;

`ifdef REGXFER_FLAGS_EN
   localparam int FLG = 1;
`else
   localparam int FLG = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [2:0]  cmd_src;
   logic [2:0]  cmd_dst;
   logic [2:0]  rf_s_out;
   logic        rf_out_en;
   logic [15:0] rf_d_out;
   logic [2:0]  rf_s_in;
   logic [15:0] rf_d_in;
   logic        rf_write_en;
   logic        done;
   logic        err;

   logic [15:0] regs [0:7];
   logic        pre_en;
   logic [2:0]  pre_sel;
   logic [15:0] pre_val;

   int ncmp  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   reg_xfer_ctrl #(.DW(16), .SELW(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_src     (cmd_src),
      .cmd_dst     (cmd_dst),
      .rf_s_out    (rf_s_out),
      .rf_out_en   (rf_out_en),
      .rf_d_out    (rf_d_out),
      .rf_s_in     (rf_s_in),
      .rf_d_in     (rf_d_in),
      .rf_write_en (rf_write_en),
      .done        (done),
      .err         (err)
   );

   // Register file model: FR keeps 4 bits; preload port shares the write path.
   always @(posedge clk) begin
      if (rf_write_en)
         regs[rf_s_in] <= (rf_s_in == 3'd3) ? {12'h000, rf_d_in[3:0]} : rf_d_in;
      else if (pre_en)
         regs[pre_sel] <= (pre_sel == 3'd3) ? {12'h000, pre_val[3:0]} : pre_val;
   end

   assign rf_d_out = rf_out_en ? regs[rf_s_out] : 16'hzzzz;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [2:0] sel, input logic [15:0] val);
      @(negedge clk);
      pre_en = 1'b1; pre_sel = sel; pre_val = val;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                          output int done_c, output int err_c, output int wr_c,
                          output int rd_c, output int rdy_low, output int both,
                          output logic rdy_after);
      done_c = -1; err_c = -1; wr_c = 0; rd_c = 0; rdy_low = 0; both = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_src = s; cmd_dst = d;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) @(negedge clk);
         if (rf_write_en) wr_c++;
         if (rf_out_en) rd_c++;
         if (!cmd_ready) rdy_low++;
         if (rf_write_en && rf_out_en) both++;
         if (done) begin done_c = c; break; end
         if (err) begin err_c = c; break; end
      end
      @(negedge clk);
      rdy_after = cmd_ready;
   endtask

   int   dc, ec, wc, rc, rl, bc;
   logic ra;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 3'd0; cmd_dst = 3'd0;
      pre_en = 1'b0; pre_sel = 3'd0; pre_val = 16'h0;
      for (int i = 0; i < 8; i++) regs[i] = 16'h0;
      #12;
      check("rst_ready",  {31'd0, cmd_ready},   32'd1);
      check("rst_outs",   {26'd0, rf_out_en, rf_write_en, done, err, 2'b00}, 32'd0);
      check("rst_sel",    {26'd0, rf_s_out, rf_s_in}, 32'd0);
      check("rst_din",    {16'd0, rf_d_in}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // MOV ACC -> X
      preload(3'd0, 16'h1234);
      run_cmd(2'b00, 3'd0, 3'd1, dc, ec, wc, rc, rl, bc, ra);
      check("mov_x",      {16'd0, regs[1]}, 32'h1234);
      check("mov_done",   dc, 2);
      check("mov_wr",     wc, 1);
      check("mov_rdy",    {31'd0, ra}, 32'd1);
      check("mov_both",   bc, 0);

      // INC Y=FFFF wraps to 0
      preload(3'd3, 16'h000A);
      preload(3'd2, 16'hFFFF);
      run_cmd(2'b01, 3'd2, 3'd2, dc, ec, wc, rc, rl, bc, ra);
      check("inc_y",      {16'd0, regs[2]}, 32'h0000);
      check("inc_done",   dc, (FLG != 0) ? 3 : 2);
      check("inc_fr",     {16'd0, regs[3]}, (FLG != 0) ? 32'h5 : 32'hA);
      check("inc_wr",     wc, (FLG != 0) ? 2 : 1);

      // SWAP ACC <-> X
      preload(3'd0, 16'h00AA);
      preload(3'd1, 16'h5500);
      run_cmd(2'b11, 3'd0, 3'd1, dc, ec, wc, rc, rl, bc, ra);
      check("swap_acc",   {16'd0, regs[0]}, 32'h5500);
      check("swap_x",     {16'd0, regs[1]}, 32'h00AA);
      check("swap_done",  dc, 4);
      check("swap_rdylo", rl, 4);
      check("swap_wr",    wc, 2);
      check("swap_rd",    rc, 2);
      check("swap_both",  bc, 0);

      // Invalid source index
      run_cmd(2'b00, 3'd6, 3'd0, dc, ec, wc, rc, rl, bc, ra);
      check("err_cyc",    ec, 1);
      check("err_done",   dc, -1);
      check("err_rfacc",  wc + rc, 0);
      check("err_rdy",    {31'd0, ra}, 32'd1);
      check("err_acc",    {16'd0, regs[0]}, 32'h5500);

      // DEC SP=0 wraps to FFFF
      preload(3'd3, 16'h0009);
      preload(3'd4, 16'h0000);
      run_cmd(2'b10, 3'd4, 3'd4, dc, ec, wc, rc, rl, bc, ra);
      check("dec_sp",     {16'd0, regs[4]}, 32'hFFFF);
      check("dec_fr",     {16'd0, regs[3]}, (FLG != 0) ? 32'h6 : 32'h9);
      check("dec_done",   dc, (FLG != 0) ? 3 : 2);

      // INC targeting FR: 0xF+1 trims to 0, no flag state
      preload(3'd3, 16'h000F);
      run_cmd(2'b01, 3'd3, 3'd3, dc, ec, wc, rc, rl, bc, ra);
      check("incfr_val",  {16'd0, regs[3]}, 32'h0);
      check("incfr_done", dc, 2);

      // SWAP with src==dst leaves the register unchanged
      preload(3'd5, 16'hBEEF);
      run_cmd(2'b11, 3'd5, 3'd5, dc, ec, wc, rc, rl, bc, ra);
      check("swapsame_pc", {16'd0, regs[5]}, 32'hBEEF);
      check("swapsame_wr", wc, 2);

      // Reset during RD2 of a SWAP
      preload(3'd0, 16'h1111);
      preload(3'd1, 16'h2222);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b11; cmd_src = 3'd0; cmd_dst = 3'd1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("rd2_outen",  {31'd0, rf_out_en}, 32'd1);
      rst = 1'b1;
      #1;
      check("rstmid_outs", {27'd0, rf_out_en, rf_write_en, done, err, cmd_ready}, 32'd1);
      check("rstmid_sel",  {26'd0, rf_s_out, rf_s_in}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_wen", {31'd0, rf_write_en}, 32'd0);
      check("rstmid_acc", {16'd0, regs[0]}, 32'h1111);
      check("rstmid_x",   {16'd0, regs[1]}, 32'h2222);
      run_cmd(2'b00, 3'd0, 3'd2, dc, ec, wc, rc, rl, bc, ra);
      check("post_y",     {16'd0, regs[2]}, 32'h1111);
      check("post_done",  dc, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
